// File: rtl/imm_gen_pipe.sv
// ---------------------------------------------------------------------------
// imm_gen_pipe
//   RISC-V immediate generator with a registered, back-pressured output.
//   Decode of the immediate, its format code and an illegal-opcode flag is
//   combinational. It is captured into an output register, or into a single
//   skid register when the output register is full and stalled. in_ready is a
//   register, so upstream timing never depends on out_ready.
//
// Parameters
//   XLEN          immediate / datapath width, 32 or 64
//   TAG_W         width of the opaque sideband tag
//   ILLEGAL_FILL  immediate presented for unrecognised opcodes
//
// Ports
//   clk          clock, rising edge
//   rst_n        synchronous active-low reset
//   in_valid     upstream instruction valid
//   in_ready     block can accept an instruction this cycle
//   in_instr     raw 32-bit instruction word
//   in_tag       sideband returned with the result
//   out_valid    result valid
//   out_ready    downstream accepts the result
//   out_imm      decoded immediate
//   out_fmt      0 I, 1 S, 2 B, 3 U, 4 J, 5 SHAMT, 6 ZIMM, 7 NONE
//   out_illegal  opcode not recognised for this XLEN
//   out_tag      tag of the result in the output register
//   illegal_cnt  saturating count of illegal results consumed downstream
// ---------------------------------------------------------------------------
module imm_gen_pipe #(
  parameter int              XLEN         = 32,
  parameter int              TAG_W        = 4,
  parameter logic [XLEN-1:0] ILLEGAL_FILL = {XLEN{1'b1}}
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [31:0]       in_instr,
  input  logic [TAG_W-1:0]  in_tag,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [XLEN-1:0]   out_imm,
  output logic [2:0]        out_fmt,
  output logic              out_illegal,
  output logic [TAG_W-1:0]  out_tag,
  output logic [15:0]       illegal_cnt
);

  generate
    if (XLEN != 32 && XLEN != 64) begin : g_bad_xlen
      $error("imm_gen_pipe: XLEN must be 32 or 64");
    end
  endgenerate

  localparam logic [2:0] FMT_I     = 3'd0;
  localparam logic [2:0] FMT_S     = 3'd1;
  localparam logic [2:0] FMT_B     = 3'd2;
  localparam logic [2:0] FMT_U     = 3'd3;
  localparam logic [2:0] FMT_J     = 3'd4;
  localparam logic [2:0] FMT_SHAMT = 3'd5;
  localparam logic [2:0] FMT_ZIMM  = 3'd6;
  localparam logic [2:0] FMT_NONE  = 3'd7;

  localparam logic [6:0] OPC_LOAD    = 7'b0000011;
  localparam logic [6:0] OPC_MISCMEM = 7'b0001111;
  localparam logic [6:0] OPC_OPIMM   = 7'b0010011;
  localparam logic [6:0] OPC_AUIPC   = 7'b0010111;
  localparam logic [6:0] OPC_OPIMM32 = 7'b0011011;
  localparam logic [6:0] OPC_STORE   = 7'b0100011;
  localparam logic [6:0] OPC_OP      = 7'b0110011;
  localparam logic [6:0] OPC_LUI     = 7'b0110111;
  localparam logic [6:0] OPC_OP32    = 7'b0111011;
  localparam logic [6:0] OPC_BRANCH  = 7'b1100011;
  localparam logic [6:0] OPC_JALR    = 7'b1100111;
  localparam logic [6:0] OPC_JAL     = 7'b1101111;
  localparam logic [6:0] OPC_SYSTEM  = 7'b1110011;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  // ---- stage p0: combinational decode ----
  logic [6:0]            w_opc_p0;
  logic [2:0]            w_f3_p0;
  logic                  w_is_shift_p0;
  logic signed [11:0]    w_imm_i_p0;
  logic signed [11:0]    w_imm_s_p0;
  logic signed [12:0]    w_imm_b_p0;
  logic signed [31:0]    w_imm_u_p0;
  logic signed [20:0]    w_imm_j_p0;
  logic [XLEN-1:0]       w_shamt_p0;
  logic [XLEN-1:0]       w_dec_imm_p0;
  logic [2:0]            w_dec_fmt_p0;
  logic                  w_dec_ill_p0;

  assign w_opc_p0      = in_instr[6:0];
  assign w_f3_p0       = in_instr[14:12];
  assign w_is_shift_p0 = (w_f3_p0[1:0] == 2'b01);
  assign w_imm_i_p0    = in_instr[31:20];
  assign w_imm_s_p0    = {in_instr[31:25], in_instr[11:7]};
  assign w_imm_b_p0    = {in_instr[31], in_instr[7], in_instr[30:25], in_instr[11:8], 1'b0};
  assign w_imm_u_p0    = {in_instr[31:12], 12'h000};
  assign w_imm_j_p0    = {in_instr[31], in_instr[19:12], in_instr[20], in_instr[30:21], 1'b0};
  // RV64 shifts take a 6-bit shamt, RV32 a 5-bit one.
  assign w_shamt_p0    = (XLEN == 64) ? XLEN'(in_instr[25:20]) : XLEN'(in_instr[24:20]);

  always_comb begin
    w_dec_imm_p0 = '0;
    w_dec_fmt_p0 = FMT_NONE;
    w_dec_ill_p0 = 1'b0;
    case (w_opc_p0)
      OPC_JALR, OPC_LOAD: begin
        w_dec_imm_p0 = XLEN'(w_imm_i_p0);
        w_dec_fmt_p0 = FMT_I;
      end
      OPC_OPIMM: begin
        if (w_is_shift_p0) begin
          w_dec_imm_p0 = w_shamt_p0;
          w_dec_fmt_p0 = FMT_SHAMT;
        end else begin
          w_dec_imm_p0 = XLEN'(w_imm_i_p0);
          w_dec_fmt_p0 = FMT_I;
        end
      end
      OPC_OPIMM32: begin
        if (XLEN == 64) begin
          // *W shifts always use a 5-bit shamt, even on RV64.
          if (w_is_shift_p0) begin
            w_dec_imm_p0 = XLEN'(in_instr[24:20]);
            w_dec_fmt_p0 = FMT_SHAMT;
          end else begin
            w_dec_imm_p0 = XLEN'(w_imm_i_p0);
            w_dec_fmt_p0 = FMT_I;
          end
        end else begin
          w_dec_ill_p0 = 1'b1;
        end
      end
      OPC_STORE: begin
        w_dec_imm_p0 = XLEN'(w_imm_s_p0);
        w_dec_fmt_p0 = FMT_S;
      end
      OPC_BRANCH: begin
        w_dec_imm_p0 = XLEN'(w_imm_b_p0);
        w_dec_fmt_p0 = FMT_B;
      end
      OPC_LUI, OPC_AUIPC: begin
        w_dec_imm_p0 = XLEN'(w_imm_u_p0);
        w_dec_fmt_p0 = FMT_U;
      end
      OPC_JAL: begin
        w_dec_imm_p0 = XLEN'(w_imm_j_p0);
        w_dec_fmt_p0 = FMT_J;
      end
      OPC_SYSTEM: begin
        // funct3[2] selects the CSR*I forms whose rs1 field is a zimm.
        if (w_f3_p0[2]) begin
          w_dec_imm_p0 = XLEN'(in_instr[19:15]);
          w_dec_fmt_p0 = FMT_ZIMM;
        end
      end
      OPC_OP, OPC_MISCMEM: begin
        w_dec_fmt_p0 = FMT_NONE;
      end
      OPC_OP32: begin
        if (XLEN != 64) w_dec_ill_p0 = 1'b1;
      end
      default: begin
        w_dec_ill_p0 = 1'b1;
      end
    endcase
    if (w_dec_ill_p0) begin
      w_dec_imm_p0 = ILLEGAL_FILL;
      w_dec_fmt_p0 = FMT_NONE;
    end
  end

  // ---- stage p1: output register + skid register ----
  logic                  r_in_ready;
  logic                  r_out_vld_p1;
  logic [XLEN-1:0]       r_out_imm_p1;
  logic [2:0]            r_out_fmt_p1;
  logic                  r_out_ill_p1;
  logic [TAG_W-1:0]      r_out_tag_p1;
  logic                  r_skid_vld_p1;
  logic [XLEN-1:0]       r_skid_imm_p1;
  logic [2:0]            r_skid_fmt_p1;
  logic                  r_skid_ill_p1;
  logic [TAG_W-1:0]      r_skid_tag_p1;
  logic [15:0]           r_illegal_cnt;

  logic                  w_acc;
  logic                  w_cons;
  logic                  w_out_free;

  assign w_acc      = in_valid && r_in_ready;
  assign w_cons     = r_out_vld_p1 && out_ready;
  assign w_out_free = !r_out_vld_p1 || out_ready;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_in_ready    <= 1'b1;
      r_out_vld_p1  <= 1'b0;
      r_skid_vld_p1 <= 1'b0;
      r_out_imm_p1  <= '0;
      r_out_fmt_p1  <= FMT_NONE;
      r_out_ill_p1  <= 1'b0;
      r_out_tag_p1  <= '0;
      r_illegal_cnt <= '0;
    end else begin
      if (w_cons && r_out_ill_p1) r_illegal_cnt <= sat_inc16(r_illegal_cnt);
      if (w_out_free) begin
        // A full skid implies in_ready was low, so nothing new is accepted here.
        if (r_skid_vld_p1) begin
          r_out_vld_p1  <= 1'b1;
          r_out_imm_p1  <= r_skid_imm_p1;
          r_out_fmt_p1  <= r_skid_fmt_p1;
          r_out_ill_p1  <= r_skid_ill_p1;
          r_out_tag_p1  <= r_skid_tag_p1;
          r_skid_vld_p1 <= 1'b0;
          r_in_ready    <= 1'b1;
        end else if (w_acc) begin
          r_out_vld_p1  <= 1'b1;
          r_out_imm_p1  <= w_dec_imm_p0;
          r_out_fmt_p1  <= w_dec_fmt_p0;
          r_out_ill_p1  <= w_dec_ill_p0;
          r_out_tag_p1  <= in_tag;
        end else begin
          r_out_vld_p1  <= 1'b0;
        end
      end else if (w_acc) begin
        r_skid_vld_p1 <= 1'b1;
        r_in_ready    <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!w_out_free && w_acc) begin
      r_skid_imm_p1 <= w_dec_imm_p0;
      r_skid_fmt_p1 <= w_dec_fmt_p0;
      r_skid_ill_p1 <= w_dec_ill_p0;
      r_skid_tag_p1 <= in_tag;
    end
  end

  assign in_ready    = r_in_ready;
  assign out_valid   = r_out_vld_p1;
  assign out_imm     = r_out_imm_p1;
  assign out_fmt     = r_out_fmt_p1;
  assign out_illegal = r_out_ill_p1;
  assign out_tag     = r_out_tag_p1;
  assign illegal_cnt = r_illegal_cnt;

endmodule

// File: tb/tb_imm_gen_pipe.sv
module tb_imm_gen_pipe;
  localparam int TAG_W = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst_n;
  logic              in_valid;
  logic              out_ready;
  logic [31:0]       in_instr;
  logic [TAG_W-1:0]  in_tag;

  logic              rdy32, vld32, ill32;
  logic [31:0]       imm32;
  logic [2:0]        fmt32;
  logic [TAG_W-1:0]  tag32;
  logic [15:0]       cnt32;

  logic              rdy64, vld64, ill64;
  logic [63:0]       imm64;
  logic [2:0]        fmt64;
  logic [TAG_W-1:0]  tag64;
  logic [15:0]       cnt64;

  imm_gen_pipe #(.XLEN(32), .TAG_W(TAG_W)) u32 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy32),
    .in_instr(in_instr), .in_tag(in_tag), .out_valid(vld32), .out_ready(out_ready),
    .out_imm(imm32), .out_fmt(fmt32), .out_illegal(ill32), .out_tag(tag32),
    .illegal_cnt(cnt32)
  );

  imm_gen_pipe #(.XLEN(64), .TAG_W(TAG_W)) u64 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy64),
    .in_instr(in_instr), .in_tag(in_tag), .out_valid(vld64), .out_ready(out_ready),
    .out_imm(imm64), .out_fmt(fmt64), .out_illegal(ill64), .out_tag(tag64),
    .illegal_cnt(cnt64)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic longint sx(input longint v, input int bits);
    if (v >= (longint'(1) <<< (bits - 1))) return v - (longint'(1) <<< bits);
    return v;
  endfunction

  function automatic void ref_decode(input int xlen, input logic [31:0] w,
                                     output logic [63:0] imm, output logic [2:0] fmt,
                                     output logic ill);
    longint     v;
    logic [2:0] f3;
    f3  = w[14:12];
    v   = 0;
    fmt = 3'd7;
    ill = 1'b0;
    case (w[6:0])
      7'b1100111, 7'b0000011: begin fmt = 3'd0; v = sx(longint'(w[31:20]), 12); end
      7'b0010011: begin
        if (f3 == 3'b001 || f3 == 3'b101) begin
          fmt = 3'd5;
          v = (xlen == 64) ? longint'(w[25:20]) : longint'(w[24:20]);
        end else begin
          fmt = 3'd0; v = sx(longint'(w[31:20]), 12);
        end
      end
      7'b0011011: begin
        if (xlen != 64) ill = 1'b1;
        else if (f3 == 3'b001 || f3 == 3'b101) begin fmt = 3'd5; v = longint'(w[24:20]); end
        else begin fmt = 3'd0; v = sx(longint'(w[31:20]), 12); end
      end
      7'b0100011: begin fmt = 3'd1; v = sx(longint'({w[31:25], w[11:7]}), 12); end
      7'b1100011: begin fmt = 3'd2; v = sx(longint'({w[31], w[7], w[30:25], w[11:8], 1'b0}), 13); end
      7'b0110111, 7'b0010111: begin fmt = 3'd3; v = sx(longint'({w[31:12], 12'h000}), 32); end
      7'b1101111: begin fmt = 3'd4; v = sx(longint'({w[31], w[19:12], w[20], w[30:21], 1'b0}), 21); end
      7'b1110011: if (f3[2]) begin fmt = 3'd6; v = longint'(w[19:15]); end
      7'b0110011, 7'b0001111: v = 0;
      7'b0111011: if (xlen != 64) ill = 1'b1;
      default: ill = 1'b1;
    endcase
    if (ill) v = -1;
    imm = (xlen == 32) ? (64'(v) & 64'h0000_0000_FFFF_FFFF) : 64'(v);
  endfunction

  typedef struct { logic [31:0] ins; logic [TAG_W-1:0] tag; } item_t;
  item_t       q[$];
  logic [15:0] m_cnt32 = '0;
  logic [15:0] m_cnt64 = '0;
  bit          rst_prev = 1'b1;
  bit          acc_last = 1'b0;

  // Two-entry FIFO view of the block: the head is what out_* must show.
  always @(posedge clk) begin
    logic [63:0] ei;
    logic [2:0]  ef;
    logic        el;
    bit          can_acc;
    bit          cons;
    acc_last = 1'b0;
    if (!rst_n) begin
      q.delete();
      m_cnt32  = '0;
      m_cnt64  = '0;
      rst_prev = 1'b1;
    end else begin
      rst_prev = 1'b0;
      can_acc  = (q.size() < 2);
      cons     = (q.size() > 0) && out_ready;
      if (cons) begin
        ref_decode(32, q[0].ins, ei, ef, el);
        if (el && m_cnt32 != 16'hFFFF) m_cnt32 = m_cnt32 + 16'd1;
        ref_decode(64, q[0].ins, ei, ef, el);
        if (el && m_cnt64 != 16'hFFFF) m_cnt64 = m_cnt64 + 16'd1;
        void'(q.pop_front());
      end
      if (in_valid && can_acc) begin
        q.push_back('{ins: in_instr, tag: in_tag});
        acc_last = 1'b1;
      end
    end
  end

  task automatic check_dut(input string nm, input int xlen, input logic vld, input logic rdy,
                           input logic [63:0] imm, input logic [2:0] fmt, input logic ill,
                           input logic [TAG_W-1:0] tag, input logic [15:0] cnt,
                           input logic [15:0] ecnt);
    logic [63:0] ei;
    logic [2:0]  ef;
    logic        el;
    chk({nm, ".out_valid"}, 64'(vld), 64'(q.size() > 0));
    chk({nm, ".in_ready"}, 64'(rdy), 64'(q.size() < 2));
    chk({nm, ".illegal_cnt"}, 64'(cnt), 64'(ecnt));
    if (rst_prev) begin
      chk({nm, ".rst_imm"}, imm, 64'h0);
      chk({nm, ".rst_fmt"}, 64'(fmt), 64'd7);
      chk({nm, ".rst_illegal"}, 64'(ill), 64'd0);
      chk({nm, ".rst_tag"}, 64'(tag), 64'd0);
    end else if (q.size() > 0) begin
      ref_decode(xlen, q[0].ins, ei, ef, el);
      chk({nm, ".out_imm"}, imm, ei);
      chk({nm, ".out_fmt"}, 64'(fmt), 64'(ef));
      chk({nm, ".out_illegal"}, 64'(ill), 64'(el));
      chk({nm, ".out_tag"}, 64'(tag), 64'(q[0].tag));
    end
  endtask

  // Compare process: outputs are settled by the falling edge.
  always @(negedge clk) begin
    check_dut("x32", 32, vld32, rdy32, {32'h0, imm32}, fmt32, ill32, tag32, cnt32, m_cnt32);
    check_dut("x64", 64, vld64, rdy64, imm64, fmt64, ill64, tag64, cnt64, m_cnt64);
  end

  // ---------------- stimulus ----------------
  task automatic pin(input string nm, input int xlen, input logic [31:0] w,
                     input logic [63:0] eimm, input logic [2:0] efmt, input logic eill);
    logic [63:0] i;
    logic [2:0]  f;
    logic        l;
    ref_decode(xlen, w, i, f, l);
    chk({"model_", nm, "_imm"}, i, eimm);
    chk({"model_", nm, "_fmt"}, 64'(f), 64'(efmt));
    chk({"model_", nm, "_ill"}, 64'(l), 64'(eill));
  endtask

  task automatic send(input logic [31:0] ins, input logic [TAG_W-1:0] tg);
    int n;
    n = 0;
    in_valid = 1'b1;
    in_instr = ins;
    in_tag   = tg;
    do begin
      @(negedge clk);
      n++;
    end while (!acc_last && n < 50);
    chk("send_accepted", 64'(acc_last), 64'd1);
  endtask

  logic [6:0] ops [0:12] = '{7'h67, 7'h03, 7'h13, 7'h1B, 7'h23, 7'h63, 7'h37,
                             7'h17, 7'h6F, 7'h73, 7'h33, 7'h3B, 7'h0F};

  function automatic logic [31:0] rand_instr();
    logic [31:0] w;
    w = $urandom;
    if ($urandom_range(0, 9) != 0) w[6:0] = ops[$urandom_range(0, 12)];
    return w;
  endfunction

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete, expected $finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    in_instr  = '0;
    in_tag    = '0;

    pin("addi32",   32, 32'hFFF00093, 64'hFFFF_FFFF, 3'd0, 1'b0);
    pin("slli64",   64, 32'h03F01093, 64'h3F, 3'd5, 1'b0);
    pin("slli32",   32, 32'h03F01093, 64'h1F, 3'd5, 1'b0);
    pin("jal32",    32, 32'h8000006F, 64'hFFF0_0000, 3'd4, 1'b0);
    pin("jal64",    64, 32'h8000006F, 64'hFFFF_FFFF_FFF0_0000, 3'd4, 1'b0);
    pin("csrrwi",   32, 32'h00F15073, 64'h2, 3'd6, 1'b0);
    pin("bad7f",    32, 32'h0000007F, 64'hFFFF_FFFF, 3'd7, 1'b1);
    pin("op32_x32", 32, 32'h0000003B, 64'hFFFF_FFFF, 3'd7, 1'b1);
    pin("op32_x64", 64, 32'h0000003B, 64'h0, 3'd7, 1'b0);

    repeat (3) @(negedge clk);
    rst_n     = 1'b1;
    out_ready = 1'b1;

    send(32'hFFF00093, 4'd1);
    chk("addi_valid", 64'(vld32), 64'd1);
    chk("addi_imm32", 64'(imm32), 64'hFFFF_FFFF);
    chk("addi_fmt32", 64'(fmt32), 64'd0);
    send(32'h03F01093, 4'd2);
    chk("slli_imm64", imm64, 64'h3F);
    chk("slli_imm32", 64'(imm32), 64'h1F);
    chk("slli_fmt", 64'(fmt64), 64'd5);
    send(32'h8000006F, 4'd3);
    chk("jal_imm32", 64'(imm32), 64'hFFF0_0000);
    chk("jal_fmt", 64'(fmt32), 64'd4);
    send(32'h00F15073, 4'd4);
    chk("csrrwi_imm", 64'(imm32), 64'h2);
    chk("csrrwi_fmt", 64'(fmt32), 64'd6);
    in_valid = 1'b0;
    repeat (2) @(negedge clk);

    // Back-pressure: A in output, B in skid, C waits.
    out_ready = 1'b0;
    send(32'h00500113, 4'hA);
    send(32'hFE112E23, 4'hB);
    in_valid = 1'b1;
    in_instr = 32'h12345037;
    in_tag   = 4'hC;
    repeat (3) @(negedge clk);
    chk("abc_in_ready_low", 64'(rdy32), 64'd0);
    chk("abc_head_a", 64'(imm32), 64'h5);
    out_ready = 1'b1;
    @(negedge clk);
    chk("abc_second_b", 64'(imm32), 64'hFFFF_FFFC);
    chk("abc_b_tag", 64'(tag32), 64'hB);
    @(negedge clk);
    chk("abc_c_accepted", 64'(acc_last), 64'd1);
    chk("abc_third_c", 64'(imm32), 64'h1234_5000);
    chk("abc_c_valid", 64'(vld32), 64'd1);
    in_valid = 1'b0;
    repeat (2) @(negedge clk);

    // Illegal counter and saturation.
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      send(32'h0000007F, 4'(i));
      chk("ill_imm32", 64'(imm32), 64'hFFFF_FFFF);
      chk("ill_flag", 64'(ill32), 64'd1);
    end
    in_valid = 1'b0;
    @(negedge clk);
    chk("ill_cnt3_x32", 64'(cnt32), 64'd3);
    chk("ill_cnt3_x64", 64'(cnt64), 64'd3);
    force u32.r_illegal_cnt = 16'hFFFD;
    force u64.r_illegal_cnt = 16'hFFFD;
    m_cnt32 = 16'hFFFD;
    m_cnt64 = 16'hFFFD;
    @(negedge clk);
    release u32.r_illegal_cnt;
    release u64.r_illegal_cnt;
    for (int i = 0; i < 3; i++) send(32'h0000007F, 4'(i));
    in_valid = 1'b0;
    @(negedge clk);
    chk("ill_cnt_sat", 64'(cnt32), 64'hFFFF);

    // Reset with both registers full; in_valid held high during reset.
    out_ready = 1'b0;
    send(32'h00000013, 4'h5);
    send(32'h0000003B, 4'h6);
    in_valid = 1'b1;
    in_instr = 32'h00700093;
    rst_n    = 1'b0;
    @(negedge clk);
    chk("rst_out_valid", 64'(vld32), 64'd0);
    chk("rst_in_ready", 64'(rdy32), 64'd1);
    chk("rst_cnt", 64'(cnt32), 64'd0);
    @(negedge clk);
    rst_n     = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("rst_no_stale", 64'(vld32), 64'd0);
    end

    // Randomised traffic.
    for (int i = 0; i < 800; i++) begin
      rst_n     = ($urandom_range(0, 99) != 0);
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      in_instr  = rand_instr();
      in_tag    = 4'($urandom);
      @(negedge clk);
    end
    rst_n     = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (4) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/imm_gen_pipe.md
IMM_GEN_PIPE -- requirements
Module: imm_gen_pipe

Interface
REQ-001 Parameter XLEN, default 32, meaning datapath/immediate width; legal values 32 and 64 only, any other value SHALL fail elaboration.
REQ-002 Parameter TAG_W, default 4, meaning width of the sideband tag carried alongside each instruction.
REQ-003 Parameter ILLEGAL_FILL, default all-ones of XLEN bits, meaning the imm value driven for unrecognised opcodes.
REQ-004 clk  input  1  the single clock; all state updates on its rising edge.
REQ-005 rst_n  input  1  reset, synchronous, active-low.
REQ-006 in_valid  input  1  upstream instruction valid.
REQ-007 in_ready  output  1  block can accept an instruction this cycle.
REQ-008 in_instr  input  32  raw RV instruction word.
REQ-009 in_tag  input  TAG_W  opaque sideband, returned unchanged with the result.
REQ-010 out_valid  output  1  result valid.
REQ-011 out_ready  input  1  downstream accepts the result.
REQ-012 out_imm  output  XLEN  decoded immediate.
REQ-013 out_fmt  output  3  format code: 0 I, 1 S, 2 B, 3 U, 4 J, 5 SHAMT, 6 ZIMM, 7 NONE.
REQ-014 out_illegal  output  1  opcode not recognised for the configured XLEN.
REQ-015 out_tag  output  TAG_W  tag of the instruction held in the output register.
REQ-016 illegal_cnt  output  16  saturating count of illegal instructions handed downstream.

Function
REQ-017 Opcode fields are instr[6:0]; all immediates are sign-extended from instr[31] to XLEN, except SHAMT and ZIMM.
REQ-018 JALR 1100111, LOAD 0000011, and OP-IMM 0010011 non-shift: I format, imm = sext(instr[31:20]).
REQ-019 OP-IMM with funct3 001/101: SHAMT format, imm = zext(instr[24:20]) for XLEN=32 and zext(instr[25:20]) for XLEN=64.
REQ-020 OP-IMM-32 0011011 with XLEN=64: I format, or SHAMT format (zext(instr[24:20])) for funct3 001/101; with XLEN=32 it is illegal.
REQ-021 STORE 0100011: S format, imm = sext({instr[31:25], instr[11:7]}).
REQ-022 BRANCH 1100011: B format, imm = sext({instr[31], instr[7], instr[30:25], instr[11:8], 1'b0}).
REQ-023 LUI 0110111 and AUIPC 0010111: U format, imm = sext({instr[31:12], 12'h000}).
REQ-024 JAL 1101111: J format, imm = sext({instr[31], instr[19:12], instr[20], instr[30:21], 1'b0}).
REQ-025 SYSTEM 1110011 with funct3[2]=1: ZIMM format, imm = zext(instr[19:15]).
REQ-026 SYSTEM with funct3[2]=0, OP 0110011, OP-32 0111011 (XLEN=64 only), and MISC-MEM 0001111: NONE format, imm = 0, not illegal.
REQ-027 Any other opcode: NONE format, imm = ILLEGAL_FILL, out_illegal = 1.
REQ-028 Pipeline structure:
  - one output register plus one skid register;
  - decode is combinational ahead of the capture point.
REQ-029 Transfers: input accepted on in_valid && in_ready; output consumed on out_valid && out_ready.
REQ-030 Latency: an accepted instruction is presented on out_* the next cycle when the output register is empty or being consumed that cycle.
REQ-031 When the output register is full and not consumed, an accepted instruction goes into the skid register.
REQ-032 in_ready is a register equal to "skid register empty"; it does not depend combinationally on out_ready.
REQ-033 When the skid register is full and the output is consumed, the skid register moves to the output register and in_ready rises the next cycle.
REQ-034 While out_valid && !out_ready, all out_* values are held stable.
REQ-035 Ordering is strictly FIFO; no instruction is dropped or duplicated.
REQ-036 illegal_cnt increments on each consumed transfer with out_illegal = 1, and stays at 16'hFFFF once reached.

Reset
REQ-037 On a clk edge with rst_n = 0, the block SHALL drive:
  - out_valid = 0, skid register empty, in_ready = 1;
  - out_imm = 0, out_fmt = 7, out_illegal = 0, out_tag = 0, illegal_cnt = 0.
REQ-038 A reset mid-operation discards both held instructions without emitting them.
REQ-039 in_valid is ignored during reset cycles.

Verification
REQ-040 XLEN=32, instr 0xFFF00093 (addi), out_ready = 1 -> next cycle out_valid = 1, out_imm = 0xFFFFFFFF, out_fmt = 0.
REQ-041 XLEN=64, instr 0x03F01093 (slli shamt 63) -> out_imm = 0x000000000000003F, out_fmt = 5; same word with XLEN=32 -> out_imm = 0x1F.
REQ-042 out_ready held 0, three back-to-back valid instrs A, B, C:
  - A sits in the output register, B in the skid register;
  - in_ready = 0 from the cycle after B is accepted, so C waits;
  - after out_ready rises, the outputs are A, B, C in order with no gaps.
REQ-043 instr 0x0000007F, consumed 3 times -> out_imm = ILLEGAL_FILL, out_illegal = 1, illegal_cnt = 3; forcing the count to 0xFFFF and one more consume -> still 0xFFFF.
REQ-044 rst_n asserted with both registers full -> next cycle out_valid = 0, in_ready = 1, illegal_cnt = 0, and no stale output after release.
REQ-045 instr 0x8000006F (jal, imm -1048576) -> out_imm = 0xFFF00000, out_fmt = 4; instr 0x00F15073 (csrrwi) -> out_imm = 2, out_fmt = 6.
